// File: rtl/l1_icache_fetch_unit.sv
// Direct-mapped L1 instruction cache with fetch-group former for the fetch stage.
// One outstanding line miss is tracked by a small fill FSM; bypass and flush supported.
module l1_icache_fetch_unit #(
    parameter int FETCH_WIDTH    = 4,
    parameter int PC_W           = 32,
    parameter int INST_W         = 64,
    parameter int INDEX_BITS     = 5,
    parameter int LINE_BYTES_LOG = 5,
    localparam int TAG_W         = PC_W - INDEX_BITS - LINE_BYTES_LOG,
    localparam int LINE_W        = 8 * (2 ** LINE_BYTES_LOG)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PC_W-1:0]               PC_i,
    input  logic                          fetchReq_i,
    input  logic                          stallFetch_i,
    input  logic                          flush_i,
    input  logic [FETCH_WIDTH-1:0]        fetchLaneActive_i,
    input  logic                          instCacheBypass_i,
    input  logic [FETCH_WIDTH*INST_W-1:0] inst_i,
    input  logic [FETCH_WIDTH-1:0]        instValid_i,
    output logic [PC_W-LINE_BYTES_LOG-1:0] ic2memReqAddr_o,
    output logic                          ic2memReqValid_o,
    input  logic [TAG_W-1:0]              mem2icTag_i,
    input  logic [INDEX_BITS-1:0]         mem2icIndex_i,
    input  logic [LINE_W-1:0]             mem2icData_i,
    input  logic                          mem2icRespValid_i,
    output logic                          icMiss_o,
    output logic                          fetchReq_o,
    output logic [FETCH_WIDTH*PC_W-1:0]   instPC_o,
    output logic [FETCH_WIDTH*INST_W-1:0] inst_o,
    output logic [FETCH_WIDTH-1:0]        instValid_o
);

    localparam int INSTS_PER_LINE = (2 ** LINE_BYTES_LOG) / 8;
    localparam int NUM_LINES      = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fillState_e;

    fillState_e state, nextState;

    logic [NUM_LINES-1:0]  validArr;
    logic [TAG_W-1:0]      tagArr  [NUM_LINES];
    logic [LINE_W-1:0]     dataArr [NUM_LINES];

    logic [INDEX_BITS-1:0] lookupIndex;
    logic [TAG_W-1:0]      lookupTag;
    logic [LINE_W-1:0]     lineData;
    logic                  lookupHit;
    logic                  lookupAccept;
    logic                  missStart;
    logic                  fillMatch;

    logic [TAG_W-1:0]      missTag;
    logic [INDEX_BITS-1:0] missIndex;

    logic [FETCH_WIDTH*INST_W-1:0] hitInst;
    logic [FETCH_WIDTH-1:0]        hitValid;
    logic [FETCH_WIDTH*PC_W-1:0]   lanePC;

    assign lookupIndex = PC_i[LINE_BYTES_LOG +: INDEX_BITS];
    assign lookupTag   = PC_i[PC_W-1 -: TAG_W];
    assign lineData    = dataArr[lookupIndex];
    assign lookupHit   = validArr[lookupIndex] && (tagArr[lookupIndex] == lookupTag);

    // Lookups are only taken while no miss is outstanding and nothing overrides them.
    assign lookupAccept = fetchReq_i && !stallFetch_i && !flush_i
                          && !instCacheBypass_i && (state == IDLE);
    assign missStart    = lookupAccept && !lookupHit;

    assign fillMatch = (state == WAIT) && mem2icRespValid_i
                       && (mem2icTag_i == missTag) && (mem2icIndex_i == missIndex);

    assign icMiss_o         = (state != IDLE);
    assign ic2memReqValid_o = (state == REQ);
    assign ic2memReqAddr_o  = {missTag, missIndex};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (missStart) nextState = REQ;
            REQ:  nextState = WAIT;
            WAIT: if (fillMatch) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush_i) nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            missTag   <= '0;
            missIndex <= '0;
        end else if (missStart) begin
            missTag   <= lookupTag;
            missIndex <= lookupIndex;
        end
    end

    // Flush beats a same-cycle fill: the data lands but the line stays invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            validArr <= '0;
        end else if (flush_i) begin
            validArr <= '0;
        end else if (fillMatch) begin
            validArr[mem2icIndex_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillMatch) begin
            tagArr[mem2icIndex_i]  <= mem2icTag_i;
            dataArr[mem2icIndex_i] <= mem2icData_i;
        end
    end

    always_comb begin
        int lineOffset;
        int slot;
        hitInst  = '0;
        hitValid = '0;
        lanePC   = '0;
        lineOffset = int'(PC_i[LINE_BYTES_LOG-1:0]) >> 3;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot = lineOffset + i;
            lanePC[i*PC_W +: PC_W] = PC_i + PC_W'(8 * i);
            // Lanes past the end of the line are dropped; no second line is read.
            if (slot < INSTS_PER_LINE) begin
                hitValid[i] = fetchLaneActive_i[i];
                hitInst[i*INST_W +: INST_W] = lineData[slot*INST_W +: INST_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchReq_o  <= 1'b0;
            instPC_o    <= '0;
            inst_o      <= '0;
            instValid_o <= '0;
        end else begin
            if (!stallFetch_i) begin
                fetchReq_o <= fetchReq_i;
                instPC_o   <= lanePC;
                if (instCacheBypass_i) begin
                    inst_o      <= inst_i;
                    instValid_o <= instValid_i & fetchLaneActive_i
                                   & {FETCH_WIDTH{fetchReq_i}};
                end else if (lookupAccept && lookupHit) begin
                    inst_o      <= hitInst;
                    instValid_o <= hitValid;
                end else begin
                    inst_o      <= '0;
                    instValid_o <= '0;
                end
            end
            if (flush_i) begin
                instValid_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l1_icache_fetch_unit.sv
// Bench for l1_icache_fetch_unit: directed scenarios plus random traffic
// checked against a transparent-cache reference model.
module tb_l1_icache_fetch_unit;

    localparam int FW  = 4;
    localparam int PCW = 32;
    localparam int IW  = 64;
    localparam int IB  = 5;
    localparam int LBL = 5;
    localparam int TW  = PCW - IB - LBL;
    localparam int LW  = 8 * (2 ** LBL);

    logic              clk;
    logic              reset;
    logic [PCW-1:0]    PC_i;
    logic              fetchReq_i;
    logic              stallFetch_i;
    logic              flush_i;
    logic [FW-1:0]     fetchLaneActive_i;
    logic              instCacheBypass_i;
    logic [FW*IW-1:0]  inst_i;
    logic [FW-1:0]     instValid_i;
    logic [PCW-LBL-1:0] ic2memReqAddr_o;
    logic              ic2memReqValid_o;
    logic [TW-1:0]     mem2icTag_i;
    logic [IB-1:0]     mem2icIndex_i;
    logic [LW-1:0]     mem2icData_i;
    logic              mem2icRespValid_i;
    logic              icMiss_o;
    logic              fetchReq_o;
    logic [FW*PCW-1:0] instPC_o;
    logic [FW*IW-1:0]  inst_o;
    logic [FW-1:0]     instValid_o;

    l1_icache_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .PC_i              (PC_i),
        .fetchReq_i        (fetchReq_i),
        .stallFetch_i      (stallFetch_i),
        .flush_i           (flush_i),
        .fetchLaneActive_i (fetchLaneActive_i),
        .instCacheBypass_i (instCacheBypass_i),
        .inst_i            (inst_i),
        .instValid_i       (instValid_i),
        .ic2memReqAddr_o   (ic2memReqAddr_o),
        .ic2memReqValid_o  (ic2memReqValid_o),
        .mem2icTag_i       (mem2icTag_i),
        .mem2icIndex_i     (mem2icIndex_i),
        .mem2icData_i      (mem2icData_i),
        .mem2icRespValid_i (mem2icRespValid_i),
        .icMiss_o          (icMiss_o),
        .fetchReq_o        (fetchReq_o),
        .instPC_o          (instPC_o),
        .inst_o            (inst_o),
        .instValid_o       (instValid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: cache contents as valid/tag per line, memory as a pure function.
    bit            mValid [32];
    logic [TW-1:0] mTag   [32];
    bit            eMiss;
    bit            eReq;
    logic [26:0]   eAddr;
    logic          eFetchReq;
    logic [3:0]    eValid;
    logic [127:0]  ePC;
    logic [255:0]  eInst;

    function automatic logic [63:0] instOf(input logic [31:0] pc);
        return {pc ^ 32'h5A5AC3C3, pc + 32'h13579BDF};
    endfunction

    function automatic logic [255:0] lineOf(input logic [26:0] la);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = instOf({la, 5'(k * 8)});
        return l;
    endfunction

    task automatic setResp(input bit v, input logic [26:0] la);
        mem2icRespValid_i = v;
        mem2icTag_i       = la[26:5];
        mem2icIndex_i     = la[4:0];
        mem2icData_i      = lineOf(la);
    endtask

    task automatic modelStep();
        logic [4:0]  idx;
        logic [21:0] tg;
        int          off;
        bit          hit, acc, fillOk, newReq;
        if (reset) begin
            for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
            eMiss = 0; eReq = 0; eAddr = '0;
            eFetchReq = 1'b0; eValid = '0; ePC = '0; eInst = '0;
        end else begin
            idx = PC_i[9:5];
            tg  = PC_i[31:10];
            off = int'(PC_i[4:3]);
            hit = mValid[idx] && (mTag[idx] == tg);
            acc = fetchReq_i && !stallFetch_i && !flush_i && !instCacheBypass_i && !eMiss;
            fillOk = eMiss && !eReq && mem2icRespValid_i
                     && ({mem2icTag_i, mem2icIndex_i} == eAddr);
            if (!stallFetch_i) begin
                eFetchReq = fetchReq_i;
                for (int i = 0; i < 4; i++) ePC[i*32 +: 32] = PC_i + 32'(8 * i);
                eValid = '0;
                eInst  = '0;
                if (instCacheBypass_i) begin
                    eInst  = inst_i;
                    eValid = instValid_i & fetchLaneActive_i & {4{fetchReq_i}};
                end else if (acc && hit) begin
                    for (int i = 0; i < 4; i++) begin
                        if (off + i < 4 && fetchLaneActive_i[i]) begin
                            eValid[i] = 1'b1;
                            eInst[i*64 +: 64] = instOf(PC_i + 32'(8 * i));
                        end
                    end
                end
            end
            if (flush_i) eValid = '0;
            if (fillOk && !flush_i) begin
                mValid[mem2icIndex_i] = 1'b1;
                mTag[mem2icIndex_i]   = mem2icTag_i;
            end
            if (flush_i) for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
            newReq = acc && !hit;
            if (newReq) eAddr = {tg, idx};
            if (flush_i) eMiss = 0;
            else if (newReq) eMiss = 1;
            else if (fillOk) eMiss = 0;
            eReq = newReq;
        end
    endtask

    task automatic compareAll();
        logic [255:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (eValid[i]) mask[i*64 +: 64] = '1;
        chk("icMiss", 256'(icMiss_o), 256'(eMiss));
        chk("memReq", 256'(ic2memReqValid_o), 256'(eReq));
        if (eReq) chk("memAddr", 256'(ic2memReqAddr_o), 256'(eAddr));
        chk("fetchReq", 256'(fetchReq_o), 256'(eFetchReq));
        chk("instValid", 256'(instValid_o), 256'(eValid));
        chk("instPC", 256'(instPC_o), 256'(ePC));
        chk("inst", inst_o & mask, eInst & mask);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        reset = 1'b1;
        PC_i = '0;
        fetchReq_i = 1'b0;
        stallFetch_i = 1'b0;
        flush_i = 1'b0;
        fetchLaneActive_i = 4'hF;
        instCacheBypass_i = 1'b0;
        inst_i = '0;
        instValid_i = '0;
        setResp(0, '0);

        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("rstValid", 256'(instValid_o), 256'(0));
        chk("rstMiss", 256'(icMiss_o), 256'(0));
        chk("rstAddr", 256'(ic2memReqAddr_o), 256'(0));

        // Cold miss with a stray response, then the matching fill
        PC_i = 32'h1000; fetchReq_i = 1'b1;
        tick();
        chk("coldValid", 256'(instValid_o), 256'(0));
        chk("coldMiss", 256'(icMiss_o), 256'(1));
        chk("coldReq", 256'(ic2memReqValid_o), 256'(1));
        chk("coldAddr", 256'(ic2memReqAddr_o), 256'(27'h80));
        fetchReq_i = 1'b0;
        tick();
        chk("reqPulse", 256'(ic2memReqValid_o), 256'(0));
        tick();
        setResp(1, 27'h81);
        tick();
        chk("strayMiss", 256'(icMiss_o), 256'(1));
        setResp(1, 27'h80);
        tick();
        chk("fillMiss", 256'(icMiss_o), 256'(0));
        setResp(0, '0);
        PC_i = 32'h1000; fetchReq_i = 1'b1;
        tick();
        chk("hitValid", 256'(instValid_o), 256'(4'hF));
        chk("hitPC", 256'(instPC_o), 256'({32'h1018, 32'h1010, 32'h1008, 32'h1000}));

        // Line crossing: offset 2 leaves lanes 0 and 1
        PC_i = 32'h1010;
        tick();
        chk("crossValid", 256'(instValid_o), 256'(4'b0011));

        // Stall holds outputs while PC moves
        PC_i = 32'h1000;
        tick();
        stallFetch_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            PC_i = 32'h1008 + 32'(8 * s);
            tick();
            chk("stallPC", 256'(instPC_o[31:0]), 256'(32'h1000));
        end
        stallFetch_i = 1'b0;
        PC_i = 32'h1008;
        tick();
        chk("relPC", 256'(instPC_o[31:0]), 256'(32'h1008));
        chk("relValid", 256'(instValid_o), 256'(4'b0111));

        // Flush coincides with the matching fill of 0x2000
        PC_i = 32'h2000; fetchReq_i = 1'b1;
        tick();
        fetchReq_i = 1'b0;
        tick();
        setResp(1, 27'h100); flush_i = 1'b1;
        tick();
        flush_i = 1'b0; setResp(0, '0);
        chk("flushIdle", 256'(icMiss_o), 256'(0));
        PC_i = 32'h1000; fetchReq_i = 1'b1;
        tick();
        chk("flushA", 256'(icMiss_o), 256'(1));
        fetchReq_i = 1'b0;
        tick();
        setResp(1, 27'h80);
        tick();
        setResp(0, '0);
        PC_i = 32'h2000; fetchReq_i = 1'b1;
        tick();
        chk("flushB", 256'(icMiss_o), 256'(1));
        fetchReq_i = 1'b0;
        tick();
        setResp(1, 27'h100);
        tick();
        setResp(0, '0);

        // Reset while waiting, then a late response must be dropped
        PC_i = 32'h3000; fetchReq_i = 1'b1;
        tick();
        fetchReq_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setResp(1, 27'h180);
        tick();
        chk("lateIdle", 256'(icMiss_o), 256'(0));
        setResp(0, '0);
        fetchReq_i = 1'b1;
        tick();
        chk("lateInvalid", 256'(icMiss_o), 256'(1));
        fetchReq_i = 1'b0;
        tick();
        instCacheBypass_i = 1'b1; fetchReq_i = 1'b1;
        fetchLaneActive_i = 4'b0011; instValid_i = 4'b1111;
        for (int w = 0; w < 8; w++) inst_i[w*32 +: 32] = $urandom;
        tick();
        chk("bypValid", 256'(instValid_o), 256'(4'b0011));
        chk("bypMiss", 256'(icMiss_o), 256'(1));
        instCacheBypass_i = 1'b0; fetchReq_i = 1'b0; fetchLaneActive_i = 4'hF;
        setResp(1, 27'h180);
        tick();
        setResp(0, '0);

        // Random traffic over a few conflicting lines
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int rsel;
            logic [31:0] pc;
            pc = (32'($urandom_range(7, 4)) << 10) | (32'($urandom_range(3, 0)) << 5)
                 | (32'($urandom_range(3, 0)) << 3);
            reset = ($urandom % 300 == 0);
            flush_i = ($urandom % 60 == 0);
            stallFetch_i = ($urandom % 6 == 0);
            instCacheBypass_i = ($urandom % 10 == 0);
            fetchReq_i = ($urandom % 4 != 0);
            fetchLaneActive_i = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
            instValid_i = 4'($urandom);
            for (int w = 0; w < 8; w++) inst_i[w*32 +: 32] = $urandom;
            PC_i = pc;
            rsel = int'($urandom % 10);
            if (eMiss && rsel < 4) setResp(1, eAddr);
            else if (rsel == 4) setResp(1, eAddr + 27'd1);
            else if (rsel == 5) setResp(1, pc[31:5]);
            else setResp(0, '0);
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
